// File: rtl/pipe_skid_register.sv
// Valid/ready pipeline stage with a two-entry skid buffer; in_ready depends only on state.
// Optional flush port enabled by defining PIPE_SKID_FLUSH_EN.
module pipe_skid_register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] wd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd
`ifdef PIPE_SKID_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             load_main_wd;
    logic             load_main_skid;
    logic             load_skid;
    logic             in_xfer;
    logic             out_xfer;
    logic             flush_req;

`ifdef PIPE_SKID_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL) & ~reset;
    assign rd        = main_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Flush wins over every transition and leaves both data entries untouched.
    always_comb begin
        state_next     = state;
        load_main_wd   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_req) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state_next   = BUSY;
                        load_main_wd = 1'b1;
                    end
                end
                BUSY: begin
                    if (in_xfer && !out_xfer) begin
                        state_next = FULL;
                        load_skid  = 1'b1;
                    end else if (!in_xfer && out_xfer) begin
                        state_next = EMPTY;
                    end else if (in_xfer && out_xfer) begin
                        load_main_wd = 1'b1;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        state_next     = BUSY;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= RESET_VALUE;
            skid_q <= RESET_VALUE;
        end else begin
            if (load_main_wd) begin
                main_q <= wd;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= wd;
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_register.sv
// Self-checking bench for pipe_skid_register: directed vector table, streaming,
// reset, optional flush and a randomized scoreboard run.
module tb_pipe_skid_register;

    localparam int          W  = 32;
    localparam logic [W-1:0] RV = 32'hDEAD_BEEF;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] wd;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] rd;
    logic         flush;

    int total;
    int bad;

    pipe_skid_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wd        (wd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd)
`ifdef PIPE_SKID_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         iv;
        logic [W-1:0] wd;
        logic         ordy;
        logic         ov;
        logic         ir;
        logic [W-1:0] rd;
    } vec_t;

    vec_t vecs[14];

    task automatic applyStimulus(input logic iv, input logic [W-1:0] d, input logic ordy);
        in_valid  = iv;
        wd        = d;
        out_ready = ordy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkAll(input string name, input logic ov, input logic ir, input logic [W-1:0] d);
        checkOutput({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        checkOutput({name, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
        checkOutput({name, ".rd"}, rd, d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] q[$];

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        wd        = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset state, then in_ready rises once reset is released.
        @(posedge clk);
        #1;
        checkAll("reset", 1'b0, 1'b0, RV);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkAll("post_reset", 1'b0, 1'b1, RV);
        tick();

        // Each row: inputs held for one cycle, outputs expected before that edge.
        vecs[0]  = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b1, RV};
        vecs[1]  = '{1'b1, 32'hB, 1'b0, 1'b1, 1'b1, 32'hA};
        vecs[2]  = '{1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 32'hA};
        vecs[3]  = '{1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 32'hA};
        vecs[4]  = '{1'b1, 32'hC, 1'b1, 1'b1, 1'b0, 32'hA};
        vecs[5]  = '{1'b1, 32'hC, 1'b0, 1'b1, 1'b1, 32'hB};
        vecs[6]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hB};
        vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hC};
        vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hC};
        vecs[9]  = '{1'b1, 32'h5, 1'b0, 1'b0, 1'b1, 32'hC};
        vecs[10] = '{1'b1, 32'h6, 1'b1, 1'b1, 1'b1, 32'h5};
        vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h6};
        vecs[12] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h6};
        vecs[13] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h6};
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].wd, vecs[i].ordy);
            checkAll($sformatf("vec%0d", i), vecs[i].ov, vecs[i].ir, vecs[i].rd);
            tick();
        end

        // Full-throughput stream of 0x1..0x10 with one-cycle latency.
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b1, W'(k), 1'b1);
            checkOutput($sformatf("stream%0d.in_ready", k), {31'd0, in_ready}, 32'd1);
            if (k > 1) begin
                checkOutput($sformatf("stream%0d.rd", k), rd, W'(k - 1));
                checkOutput($sformatf("stream%0d.out_valid", k), {31'd0, out_valid}, 32'd1);
            end
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1);
        checkAll("stream_last", 1'b1, 1'b1, 32'h10);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkAll("stream_drained", 1'b0, 1'b1, 32'h10);

        // Asynchronous reset while FULL drops both words without a clock edge.
        applyStimulus(1'b1, 32'h11, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h22, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b0);
        checkAll("pre_reset_full", 1'b1, 1'b0, 32'h11);
        reset = 1'b1;
        #1;
        checkAll("async_reset", 1'b0, 1'b0, RV);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkAll("reset_release", 1'b0, 1'b1, RV);
        tick();

`ifdef PIPE_SKID_FLUSH_EN
        // Flush while FULL empties the stage and keeps main data.
        applyStimulus(1'b1, 32'h31, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h32, 1'b0);
        tick();
        flush = 1'b1;
        applyStimulus(1'b1, 32'h77, 1'b0);
        checkAll("flush_full_pre", 1'b1, 1'b0, 32'h31);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        checkAll("flush_full_post", 1'b0, 1'b1, 32'h31);
        tick();
        checkAll("flush_full_hold", 1'b0, 1'b1, 32'h31);
        // Flush in BUSY with simultaneous accept and consume discards the incoming word.
        applyStimulus(1'b1, 32'h41, 1'b0);
        tick();
        flush = 1'b1;
        applyStimulus(1'b1, 32'h88, 1'b1);
        checkAll("flush_busy_pre", 1'b1, 1'b1, 32'h41);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, '0, 1'b0);
        checkAll("flush_busy_post", 1'b0, 1'b1, 32'h41);
        tick();
`endif

        // Random handshakes against a scoreboard queue with independent occupancy.
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            logic iv;
            logic ordy;
            logic exp_ov;
            logic exp_ir;
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            applyStimulus(iv, $urandom, ordy);
            exp_ov = (q.size() != 0);
            exp_ir = (q.size() < 2);
            checkOutput("rand.out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            checkOutput("rand.in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
            if (exp_ov && ordy) begin
                checkOutput("rand.rd", rd, q[0]);
                void'(q.pop_front());
            end
            if (iv && exp_ir) begin
                q.push_back(wd);
            end
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (q.size() != 0) begin
                checkOutput("drain.rd", rd, q[0]);
                void'(q.pop_front());
            end
            tick();
        end
        checkOutput("drain.out_valid", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
